sys_irq: RTL and testbench

Machine-level interrupt unit for the superscalar core: owns the machine timer (mtime/mtimecmp), the software-interrupt bit and the interrupt-enable mask. It arbitrates pending interrupts and issues a trap-entry jump request to the scheduler, using the address in mtvec as the jump target. It supplies the epc/cause pair that the CSR unit stores into mepc/mcause, and it is re-armed by mret. It is the trap-entry side of the CSR unit's trap-return path. It sits beside the CSR unit and receives memory-mapped register writes from the load/store path.

---
 rtl/sys_irq.sv | 156 +++++++++++++++
 tb/tb_sys_irq.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_irq.sv
// sys_irq: machine timer, software and external interrupt unit issuing trap-entry requests.
// Define SYS_IRQ_EXT_EN to build the ext_irq synchroniser and the MEI source.
module sys_irq #(
  parameter int XLEN     = 32,
  parameter int TICK_DIV = 100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reg_wr,
  input  logic [2:0]      reg_addr,
  input  logic [XLEN-1:0] reg_wdata,
  output logic [XLEN-1:0] reg_rdata,
  input  logic            ext_irq,
  input  logic [XLEN-1:0] mtvec,
  output logic            irq_req,
  output logic [XLEN-1:0] irq_pc,
  input  logic            irq_ack,
  input  logic [XLEN-1:0] ack_pc,
  input  logic            mret_vld,
  output logic            epc_wr,
  output logic [XLEN-1:0] epc_data,
  output logic [XLEN-1:0] cause_data
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRE_MAX   = PW'(TICK_DIV - 1);
  localparam logic [XLEN-1:0] CAUSE_MEI = {1'b1, {(XLEN-5){1'b0}}, 4'd11};
  localparam logic [XLEN-1:0] CAUSE_MSI = {1'b1, {(XLEN-5){1'b0}}, 4'd3};
  localparam logic [XLEN-1:0] CAUSE_MTI = {1'b1, {(XLEN-5){1'b0}}, 4'd7};

  typedef enum logic [1:0] {IDLE, REQ, ACTIVE} state_t;

  state_t          state;
  logic [PW-1:0]   prescaler;
  logic [63:0]     mtime;
  logic [63:0]     mtimecmp;
  logic            msip;
  logic [2:0]      mie;        // {meie, mtie, msie} = mie bits {11, 7, 3}
  logic [XLEN-1:0] cause_q;
  logic            meip;
  logic            mtip;
  logic            mei;
  logic            msi;
  logic            mti;
  logic            take;
  logic [XLEN-1:0] win_cause;

`ifdef SYS_IRQ_EXT_EN
  logic [1:0] ext_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ext_sync <= '0;
    else      ext_sync <= {ext_sync[0], ext_irq};
  end

  assign meip = ext_sync[1];
`else
  // External source compiled out; the input is tied off here so it stays referenced.
  assign meip = 1'b0 & ext_irq;
`endif

  assign mtip = (mtime >= mtimecmp);
  assign mei  = meip & mie[2];
  assign msi  = msip & mie[0];
  assign mti  = mtip & mie[1];
  assign take = mei | msi | mti;

  assign irq_pc = mtvec;

  always_comb begin
    // NOTE: default first so every path assigns win_cause and no latch is inferred.
    win_cause = CAUSE_MTI;
    if (mei)      win_cause = CAUSE_MEI;
    else if (msi) win_cause = CAUSE_MSI;
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      3'd0:    reg_rdata = XLEN'(mtimecmp[31:0]);
      3'd1:    reg_rdata = XLEN'(mtimecmp[63:32]);
      3'd2:    reg_rdata = XLEN'(mtime[31:0]);
      3'd3:    reg_rdata = XLEN'(mtime[63:32]);
      3'd4:    reg_rdata[0] = msip;
      3'd5:    begin
        reg_rdata[3]  = mie[0];
        reg_rdata[7]  = mie[1];
        reg_rdata[11] = mie[2];
      end
      default: reg_rdata = '0;
    endcase
  end

  // Timer and memory-mapped registers; mtime is read-only from the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler <= '0;
      mtime     <= '0;
      mtimecmp  <= '1;
      msip      <= 1'b0;
      mie       <= '0;
    end else begin
      if (prescaler == PRE_MAX) begin
        prescaler <= '0;
        mtime     <= mtime + 64'd1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
      if (reg_wr) begin
        case (reg_addr)
          3'd0:    mtimecmp[31:0]  <= reg_wdata[31:0];
          3'd1:    mtimecmp[63:32] <= reg_wdata[31:0];
          3'd4:    msip            <= reg_wdata[0];
          3'd5:    mie             <= {reg_wdata[11], reg_wdata[7], reg_wdata[3]};
          default: ;
        endcase
      end
    end
  end

  // Trap-entry handshake: the cause is frozen on REQ entry and copied out on ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      irq_req    <= 1'b0;
      epc_wr     <= 1'b0;
      epc_data   <= '0;
      cause_data <= '0;
      cause_q    <= '0;
    end else begin
      // NOTE: non-blocking default; the ack branch below overrides it for one cycle.
      epc_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            state   <= REQ;
            irq_req <= 1'b1;
            cause_q <= win_cause;
          end
        end
        REQ: begin
          if (irq_ack) begin
            state      <= ACTIVE;
            irq_req    <= 1'b0;
            epc_wr     <= 1'b1;
            epc_data   <= ack_pc;
            cause_data <= cause_q;
          end
        end
        ACTIVE: begin
          if (mret_vld) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sys_irq.sv
// tb_sys_irq: directed and randomized checks of sys_irq against a cycle-level spec model,
// with trap records scoreboarded between the stimulus and an epc_wr monitor.
module tb_sys_irq;
  localparam int XLEN     = 32;
  localparam int TICK_DIV = 100;
  localparam logic [31:0] CAUSE_MEI = 32'h8000000B;
  localparam logic [31:0] CAUSE_MSI = 32'h80000003;
  localparam logic [31:0] CAUSE_MTI = 32'h80000007;
`ifdef SYS_IRQ_EXT_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reg_wr = 1'b0;
  logic [2:0]  reg_addr = 3'd0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;
  logic        ext_irq = 1'b0;
  logic [31:0] mtvec = '0;
  logic        irq_req;
  logic [31:0] irq_pc;
  logic        irq_ack = 1'b0;
  logic [31:0] ack_pc = '0;
  logic        mret_vld = 1'b0;
  logic        epc_wr;
  logic [31:0] epc_data;
  logic [31:0] cause_data;

  always #5 clk = ~clk;

  sys_irq #(.XLEN(XLEN), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst(rst), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .ext_irq(ext_irq), .mtvec(mtvec), .irq_req(irq_req),
    .irq_pc(irq_pc), .irq_ack(irq_ack), .ack_pc(ack_pc), .mret_vld(mret_vld),
    .epc_wr(epc_wr), .epc_data(epc_data), .cause_data(cause_data)
  );

  // Reference model: values visible in the current cycle (m_*) and the next (n_*).
  typedef enum int {M_IDLE, M_REQ, M_ACTIVE} mode_t;
  typedef struct { logic [31:0] pc; logic [31:0] cause; } trap_t;

  trap_t       sb[$];
  longint      m_cyc, n_cyc;
  logic [63:0] m_cmp, n_cmp;
  logic        m_msip, n_msip;
  logic [31:0] m_mie, n_mie;
  mode_t       m_mode, n_mode;
  logic [31:0] m_cause, n_cause;
  logic        m_epc_wr, n_epc_wr;
  logic        m_e1, m_e2, n_e1, n_e2;

  int n_checks = 0;
  int n_errors = 0;
  int epc_pulses = 0;
  bit mon_en = 1'b0;
  int n, p0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_mtime();
    return 64'(m_cyc / TICK_DIV);
  endfunction

  function automatic logic [31:0] model_rdata(input logic [2:0] a);
    logic [63:0] t;
    t = model_mtime();
    case (a)
      3'd0:    return m_cmp[31:0];
      3'd1:    return m_cmp[63:32];
      3'd2:    return t[31:0];
      3'd3:    return t[63:32];
      3'd4:    return {31'b0, m_msip};
      3'd5:    return m_mie;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_cmp = '1; m_msip = 1'b0; m_mie = '0; m_mode = M_IDLE;
    m_cause = '0; m_epc_wr = 1'b0; m_e1 = 1'b0; m_e2 = 1'b0;
    sb.delete();
  endtask

  task automatic model_next();
    logic mei, msi, mti;
    mei = EXT_EN && m_e2 && m_mie[11];
    msi = m_msip && m_mie[3];
    mti = (model_mtime() >= m_cmp) && m_mie[7];
    n_mode = m_mode; n_cause = m_cause; n_epc_wr = 1'b0;
    case (m_mode)
      M_IDLE: if (mei || msi || mti) begin
        n_mode  = M_REQ;
        n_cause = mei ? CAUSE_MEI : (msi ? CAUSE_MSI : CAUSE_MTI);
      end
      M_REQ: if (irq_ack) begin
        sb.push_back('{ack_pc, m_cause});
        n_mode = M_ACTIVE; n_epc_wr = 1'b1;
      end
      default: if (mret_vld) n_mode = M_IDLE;
    endcase
    n_cmp = m_cmp; n_msip = m_msip; n_mie = m_mie;
    if (reg_wr) begin
      case (reg_addr)
        3'd0:    n_cmp[31:0]  = reg_wdata;
        3'd1:    n_cmp[63:32] = reg_wdata;
        3'd4:    n_msip       = reg_wdata[0];
        3'd5:    n_mie        = reg_wdata & 32'h888;
        default: ;
      endcase
    end
    n_e2 = m_e1; n_e1 = ext_irq; n_cyc = m_cyc + 1;
  endtask

  // One clock: predict the next cycle from current inputs, take the edge, drop strobes.
  task automatic step();
    model_next();
    @(posedge clk); #1;
    m_cyc = n_cyc; m_cmp = n_cmp; m_msip = n_msip; m_mie = n_mie; m_mode = n_mode;
    m_cause = n_cause; m_epc_wr = n_epc_wr; m_e1 = n_e1; m_e2 = n_e2;
    reg_wr = 1'b0; irq_ack = 1'b0; mret_vld = 1'b0;
  endtask

  task automatic write(input logic [2:0] a, input logic [31:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    step();
  endtask

  task automatic wait_req(input int budget, input string name);
    int k;
    k = 0;
    while (!irq_req && k < budget) begin step(); k++; end
    check(name, irq_req, 1'b1);
  endtask

  // Monitor: per-cycle output compare plus scoreboard pop on each epc_wr pulse.
  always @(negedge clk) begin
    trap_t t;
    if (mon_en) begin
      check("irq_req", irq_req, m_mode == M_REQ);
      check("epc_wr", epc_wr, m_epc_wr);
      check("reg_rdata", reg_rdata, model_rdata(reg_addr));
      if (irq_req) check("irq_pc", irq_pc, mtvec);
      if (epc_wr) begin
        epc_pulses++;
        check("sb_pending", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          t = sb.pop_front();
          check("sb_epc_data", epc_data, t.pc);
          check("sb_cause_data", cause_data, t.cause);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #1;
    check("rst_irq_req", irq_req, 1'b0);
    check("rst_epc_wr", epc_wr, 1'b0);
    check("rst_epc_data", epc_data, 32'h0);
    check("rst_cause_data", cause_data, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; model_reset(); mon_en = 1'b1;

    // Timer: mtime reaches 3 in cycle 300, request one cycle later.
    write(3'd1, 32'h0);
    write(3'd0, 32'd3);
    write(3'd5, 32'h80);
    reg_addr = 3'd2;
    wait_req(400, "timer_req");
    check("timer_req_cycle", m_cyc, 64'd301);
    irq_ack = 1'b1; ack_pc = 32'h100;
    step();
    check("timer_epc_wr", epc_wr, 1'b1);
    check("timer_epc_data", epc_data, 32'h100);
    check("timer_cause", cause_data, CAUSE_MTI);
    write(3'd1, 32'hFFFF_FFFF);
    mret_vld = 1'b1; step();
    step();
    check("timer_cleared", irq_req, 1'b0);

    // Priority MSI over MTI, then re-request two cycles after mret.
    write(3'd5, 32'h0);
    write(3'd1, 32'h0);
    write(3'd0, 32'h0);
    write(3'd4, 32'h1);
    write(3'd5, 32'h88);
    wait_req(10, "prio_req");
    irq_ack = 1'b1; ack_pc = $urandom;
    step();
    check("prio_cause", cause_data, CAUSE_MSI);
    step();
    mret_vld = 1'b1; step();
    check("mret_k1", irq_req, 1'b0);
    step();
    check("mret_k2", irq_req, 1'b1);

    // Handshake hold with a moving mtvec; mret in REQ is ignored.
    mtvec = 32'h200; step();
    mret_vld = 1'b1; step();
    mtvec = 32'h300; step(); step(); step();
    check("hold_req", irq_req, 1'b1);
    check("hold_pc", irq_pc, 32'h300);
    p0 = epc_pulses;
    irq_ack = 1'b1; ack_pc = 32'h1234;
    step();
    repeat (4) step();
    check("hold_one_epc", epc_pulses - p0, 1);
    check("hold_cause", cause_data, CAUSE_MSI);
    check("hold_epc", epc_data, 32'h1234);
    write(3'd4, 32'h0);
    write(3'd5, 32'h0);
    mret_vld = 1'b1; step();

`ifdef SYS_IRQ_EXT_EN
    // Masking in ACTIVE, then MEI after mret and the 3-cycle edge latency.
    write(3'd5, 32'h808);
    write(3'd4, 32'h1);
    wait_req(10, "mask_req");
    irq_ack = 1'b1; step();
    write(3'd4, 32'h0);
    ext_irq = 1'b1;
    n = 0;
    repeat (10) begin step(); if (irq_req) n++; end
    check("mask_no_req", n, 0);
    mret_vld = 1'b1; step();
    step();
    check("mask_mei_after_mret", irq_req, 1'b1);
    irq_ack = 1'b1; step();
    check("mask_cause", cause_data, CAUSE_MEI);
    ext_irq = 1'b0;
    repeat (3) step();
    mret_vld = 1'b1; step();
    repeat (4) step();
    check("ext_dropped", irq_req, 1'b0);
    ext_irq = 1'b1;
    n = 0;
    while (!irq_req && n < 10) begin step(); n++; end
    check("ext_latency", n, 3);
    irq_ack = 1'b1; step();
    check("ext_cause", cause_data, CAUSE_MEI);
    ext_irq = 1'b0;
    repeat (3) step();
    mret_vld = 1'b1; step();
    write(3'd5, 32'h0);
`else
    // External source compiled out: MEIE alone never produces a request.
    write(3'd5, 32'h800);
    ext_irq = 1'b1; reg_addr = 3'd5;
    n = 0;
    repeat (1000) begin step(); if (irq_req) n++; end
    check("noext_no_req", n, 0);
    check("noext_mie_rb", reg_rdata, 32'h800);
    ext_irq = 1'b0;
    write(3'd5, 32'h0);
`endif

    // Read-only mtime and unmapped addresses.
    write(3'd3, 32'hDEAD_BEEF);
    reg_addr = 3'd3; #1;
    check("mtime_hi_ro", reg_rdata, 32'h0);
    write(3'd6, 32'hFFFF_FFFF);
    reg_addr = 3'd6; #1;
    check("unmapped_rd", reg_rdata, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      reg_wr = 1'b0;
      reg_addr = 3'($urandom_range(0, 7));
      if (r < 6) begin
        reg_wr = 1'b1; reg_addr = 3'd0;
        reg_wdata = 32'(model_mtime()) + 32'($urandom_range(0, 2));
      end else if (r < 8) begin
        reg_wr = 1'b1; reg_addr = 3'd1;
        reg_wdata = ($urandom_range(0, 3) == 0) ? 32'h1 : 32'h0;
      end else if (r < 13) begin
        reg_wr = 1'b1; reg_addr = 3'd4; reg_wdata = $urandom;
      end else if (r < 16) begin
        reg_wr = 1'b1; reg_addr = 3'd5; reg_wdata = $urandom;
      end else if (r < 18) begin
        reg_wr = 1'b1; reg_wdata = $urandom;
      end
      if ($urandom_range(0, 29) == 0) ext_irq = ~ext_irq;
      irq_ack  = ($urandom_range(0, 2) == 0);
      ack_pc   = $urandom;
      mret_vld = ($urandom_range(0, 7) == 0);
      mtvec    = $urandom;
      step();
    end

    // Drain to IDLE with everything masked.
    ext_irq = 1'b0;
    write(3'd5, 32'h0);
    irq_ack = 1'b1; step();
    mret_vld = 1'b1; step();
    irq_ack = 1'b1; step();
    mret_vld = 1'b1; step();
    step();
    check("sb_empty", sb.size(), 0);

    // Asynchronous reset while a request is pending.
    write(3'd4, 32'h1);
    write(3'd5, 32'h8);
    wait_req(10, "rst_req");
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_mid_irq_req", irq_req, 1'b0);
    check("rst_mid_epc_wr", epc_wr, 1'b0);
    check("rst_mid_cause", cause_data, 32'h0);
    check("rst_mid_epc", epc_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1; model_reset(); reg_addr = 3'd0; mon_en = 1'b1;
    #1;
    check("rst_cmp_lo", reg_rdata, 32'hFFFF_FFFF);
    repeat (6) step();
    check("rst_no_replay", irq_req, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
